x0_receiver: RTL and testbench
==============================

Name: x0_receiver

Overview:
- Receiving end of the X0 dual-rail send/receive link.
- Samples the sender's dual-rail bit lines (bit0/bit1), data-transmit marker (dt) and channel-clear (cclear).
- Returns a per-bit four-phase ack and a per-word senack.
- Assembles WORD_W bits into a parallel word for downstream logic, and flags protocol violations.

Parameters:
- WORD_W, 8, bits per word.
- SYNC_STAGES, 2, flip-flop synchroniser depth on each asynchronous input (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- bit0  input  1  async; dual-rail "logical 0" rail from sender
- bit1  input  1  async; dual-rail "logical 1" rail from sender
- dt  input  1  async; sender end-of-word / data-transmit marker
- cclear  input  1  async; sender channel-clear request
- ack  output  1  per-bit acknowledge to sender (registered)
- senack  output  1  per-word acknowledge to sender (registered)
- data_out  output  WORD_W  last completed word
- data_valid  output  1  one-cycle pulse when data_out updates
- bit_count  output  clog2(WORD_W+1)  bits received in the current word
- frame_err  output  1  sticky protocol-error flag

Behaviour:
- Inputs: bit0, bit1, dt and cclear each pass through SYNC_STAGES flops. All decisions below use the synchronised values (s_bit0, s_bit1, s_dt, s_cclear).
- Symbol decode:
  - exactly one rail high = valid symbol, value = s_bit1
  - both rails low = spacer
  - both rails high = illegal
- Reset (reset=1 at a clock edge):
  - state=IDLE
  - ack=0, senack=0, data_valid=0, frame_err=0
  - bit_count=0, shift register=0, data_out=0, synchroniser flops=0
  - reset has priority over everything.
- Priority in every state: s_cclear > state-specific rules. While s_cclear=1:
  - state=IDLE, bit_count=0, shift register=0
  - ack=0, senack=0, frame_err=0
  - data_out retained
  - no capture occurs
- IDLE (ack=0, senack=0). Checks in order:
  1. illegal symbol -> ERR.
  2. s_dt=1 together with a valid symbol -> ERR.
  3. s_dt=1 with bit_count==WORD_W -> data_out<=shift register, data_valid=1 for exactly one cycle, senack<=1, go SEN.
  4. s_dt=1 with bit_count!=WORD_W -> ERR (short word).
  5. valid symbol with bit_count==WORD_W -> ERR (overrun).
  6. valid symbol otherwise -> shift_reg[bit_count]<=s_bit1 (LSB first), bit_count+1, ack<=1, go ACK.
  7. spacer -> stay.
- ACK (ack=1):
  - hold until spacer, then ack<=0 and go IDLE.
  - illegal symbol while waiting -> ERR.
  - A rail change between the two valid values is ignored; no second capture.
- SEN (senack=1):
  - hold until s_dt=0, then senack<=0, bit_count<=0, shift register<=0, go IDLE.
  - any symbol while in SEN is ignored.
- ERR:
  - frame_err=1, ack=0, senack=0, no captures.
  - leave only via s_cclear or reset.
- Latency:
  - ack rises SYNC_STAGES+1 clocks after a clean rail edge at the pin.
  - data_valid and senack rise SYNC_STAGES+1 clocks after the dt pin rises.
- bit_count saturates at WORD_W and never wraps.
- data_valid is never high in two consecutive cycles.

Optional Feature:
- X0RX_PARITY_EN defined:
  - A word is WORD_W data bits plus one trailing even-parity bit.
  - The dt check in IDLE uses bit_count==WORD_W+1; the overrun check likewise.
  - bit_count is widened to clog2(WORD_W+2).
  - Parity bit is not placed in data_out.
  - On parity mismatch at dt: go ERR, frame_err=1, no data_valid, no senack, data_out unchanged.
- Undefined: plain WORD_W-bit words, no parity logic present.

Test Plan:
- Word send: reset, then drive 8 dual-rail symbols for 0xA5 LSB first, each as rail high -> wait ack=1 -> rails low -> wait ack=0, then dt=1 -> data_out=0xA5, one-cycle data_valid, senack=1 until dt=0, bit_count returns 0.
- Short word: 5 bits, then dt=1 -> frame_err=1, no data_valid, ack=senack=0. Then cclear pulse -> frame_err=0, bit_count=0, data_out unchanged.
- Illegal symbol: bit0=bit1=1 in IDLE and again mid-ACK -> ERR entered within SYNC_STAGES+1 clocks each time, ack forced 0.
- Overrun: 9 bits without dt -> ERR on the 9th, bit_count stays 8.
- Reset mid-word: reset=1 during ACK after 3 bits -> next cycle ack=0, bit_count=0, data_out=0. A following full 0x3C word is received correctly.
- X0RX_PARITY_EN: 0x0F+parity 0 -> data_out=0x0F, data_valid. 0x0F+parity 1 -> frame_err=1, data_out retains 0x0F from the prior word.

Source files
------------

// File: rtl/x0_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : x0_receiver                                                     |
// | Purpose  : X0 dual-rail link receiver. Synchronises the sender's rails,    |
// |            acks each bit, assembles words, senacks each word, flags errors.|
// | Option   : X0RX_PARITY_EN appends one even-parity bit to every word.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module x0_receiver #(
  parameter int WORD_W      = 8,
  parameter int SYNC_STAGES = 2,
`ifdef X0RX_PARITY_EN
  localparam int NBITS      = WORD_W + 1,
`else
  localparam int NBITS      = WORD_W,
`endif
  localparam int CW         = $clog2(NBITS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit0,
  input  logic              bit1,
  input  logic              dt,
  input  logic              cclear,
  output logic              ack,
  output logic              senack,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic [CW-1:0]     bit_count,
  output logic              frame_err
);

  localparam logic [CW-1:0] C_FULL = CW'(NBITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_SEN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Each stage holds {cclear, dt, bit1, bit0}; the last stage is the clean copy.
  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0]                  w_s;
  logic                        w_s_bit0, w_s_bit1, w_s_dt, w_s_cclear;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [NBITS-1:0]  r_shift, w_shift_nxt;
  logic [WORD_W-1:0] r_dout, w_dout_nxt;
  logic              r_ack, r_senack, r_dv, r_ferr;
  logic              w_dv_nxt;
  logic              w_valid, w_illegal, w_spacer, w_par_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], cclear, dt, bit1, bit0};
    end
  end

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_s_bit0   = w_s[0];
  assign w_s_bit1   = w_s[1];
  assign w_s_dt     = w_s[2];
  assign w_s_cclear = w_s[3];

  assign w_valid   = w_s_bit0 ^ w_s_bit1;
  assign w_illegal = w_s_bit0 & w_s_bit1;
  assign w_spacer  = ~(w_s_bit0 | w_s_bit1);

`ifdef X0RX_PARITY_EN
  // Data plus trailing parity bit must contain an even number of ones.
  assign w_par_ok = ~(^r_shift);
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_dout;
    w_dv_nxt    = 1'b0;
    if (w_s_cclear) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_illegal) begin
            w_state_nxt = ST_ERR;
          end else if (w_s_dt && w_valid) begin
            w_state_nxt = ST_ERR;
          end else if (w_s_dt && (r_cnt == C_FULL)) begin
            if (w_par_ok) begin
              w_dout_nxt  = r_shift[WORD_W-1:0];
              w_dv_nxt    = 1'b1;
              w_state_nxt = ST_SEN;
            end else begin
              w_state_nxt = ST_ERR;
            end
          end else if (w_s_dt) begin
            w_state_nxt = ST_ERR;
          end else if (w_valid && (r_cnt == C_FULL)) begin
            w_state_nxt = ST_ERR;
          end else if (w_valid) begin
            w_shift_nxt = r_shift | (NBITS'(w_s_bit1) << r_cnt);
            w_cnt_nxt   = r_cnt + CW'(1);
            w_state_nxt = ST_ACK;
          end
        end
        ST_ACK: begin
          // A hop between the two valid rails is not a new symbol.
          if (w_illegal) begin
            w_state_nxt = ST_ERR;
          end else if (w_spacer) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SEN: begin
          if (!w_s_dt) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_ERR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_dout    <= '0;
      r_ack     <= 1'b0;
      r_senack  <= 1'b0;
      r_dv      <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_dout    <= w_dout_nxt;
      r_ack     <= (w_state_nxt == ST_ACK);
      r_senack  <= (w_state_nxt == ST_SEN);
      r_dv      <= w_dv_nxt;
      r_ferr    <= (w_state_nxt == ST_ERR);
    end
  end

  assign ack        = r_ack;
  assign senack     = r_senack;
  assign data_out   = r_dout;
  assign data_valid = r_dv;
  assign bit_count  = r_cnt;
  assign frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_x0_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_x0_receiver                                                  |
// | Purpose  : Self-checking bench for x0_receiver with a word scoreboard.     |
// | Option   : X0RX_PARITY_EN adds the parity word cases.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_x0_receiver;
  localparam int WORD_W      = 8;
  localparam int SYNC_STAGES = 2;
`ifdef X0RX_PARITY_EN
  localparam int NB = WORD_W + 1;
`else
  localparam int NB = WORD_W;
`endif
  localparam int CW  = $clog2(NB + 1);
  localparam int LAT = SYNC_STAGES + 1;

  logic              clk = 1'b0;
  logic              reset, bit0, bit1, dt, cclear;
  logic              ack, senack, data_valid, frame_err;
  logic [WORD_W-1:0] data_out;
  logic [CW-1:0]     bit_count;

  int                n_checks = 0;
  int                n_errors = 0;
  int                n_dv     = 0;
  int                n_push   = 0;
  logic              r_prev_dv = 1'b0;
  logic [WORD_W-1:0] sb_q[$];
  logic [WORD_W-1:0] exp_last;

  x0_receiver #(.WORD_W(WORD_W), .SYNC_STAGES(SYNC_STAGES)) u_dut (
    .clk(clk), .reset(reset), .bit0(bit0), .bit1(bit1), .dt(dt), .cclear(cclear),
    .ack(ack), .senack(senack), .data_out(data_out), .data_valid(data_valid),
    .bit_count(bit_count), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completed words are matched against the scoreboard as they appear.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      n_dv++;
      check_value("dv_back_to_back", r_prev_dv, 0);
      check_value("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) check_value("data_out", data_out, sb_q.pop_front());
    end
    r_prev_dv = data_valid;
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return ack;
      1:       return senack;
      default: return frame_err;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(which) !== val && n < 40);
  endtask

  task automatic send_bit(input logic b, output int lat);
    int n;
    bit1 = b; bit0 = ~b;
    wait_for(0, 1'b1, lat);
    check_value("ack_rise", ack, 1);
    bit1 = 1'b0; bit0 = 1'b0;
    wait_for(0, 1'b0, n);
    check_value("ack_fall", ack, 0);
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input int nbits, input logic badpar);
    int lat;
    for (int i = 0; i < nbits; i++) send_bit(w[i], lat);
`ifdef X0RX_PARITY_EN
    if (nbits == WORD_W) send_bit((^w) ^ badpar, lat);
`endif
  endtask

  task automatic send_dt(input logic [WORD_W-1:0] w);
    int lat, n;
    sb_q.push_back(w);
    n_push++;
    exp_last = w;
    dt = 1'b1;
    wait_for(1, 1'b1, lat);
    check_value("senack_rise", senack, 1);
    check_value("senack_latency", lat, LAT);
    repeat (3) @(negedge clk);
    check_value("senack_hold", senack, 1);
    check_value("dv_single", data_valid, 0);
    dt = 1'b0;
    wait_for(1, 1'b0, n);
    check_value("senack_fall", senack, 0);
    check_value("count_cleared", bit_count, 0);
  endtask

  task automatic clear_err();
    cclear = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check_value("cclear_ferr", frame_err, 0);
    check_value("cclear_count", bit_count, 0);
    check_value("cclear_dout", data_out, exp_last);
    cclear = 1'b0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  initial begin
    int lat, n, dv0;
    logic [WORD_W-1:0] w;
    reset = 1'b1; bit0 = 1'b0; bit1 = 1'b0; dt = 1'b0; cclear = 1'b0;
    exp_last = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_value("rst_ack", ack, 0);
    check_value("rst_senack", senack, 0);
    check_value("rst_dv", data_valid, 0);
    check_value("rst_ferr", frame_err, 0);
    check_value("rst_count", bit_count, 0);
    check_value("rst_dout", data_out, 0);

    // Full word 0xA5 with ack latency on the first bit.
    w = 8'hA5;
    send_bit(w[0], lat);
    check_value("ack_latency", lat, LAT);
    for (int i = 1; i < WORD_W; i++) send_bit(w[i], lat);
`ifdef X0RX_PARITY_EN
    send_bit(^w, lat);
`endif
    check_value("full_count", bit_count, NB);
    send_dt(w);

    // Short word.
    dv0 = n_dv;
    send_word(8'h1F, 5, 1'b0);
    check_value("short_count", bit_count, 5);
    dt = 1'b1;
    wait_for(2, 1'b1, n);
    repeat (2) @(negedge clk);
    check_value("short_ferr", frame_err, 1);
    check_value("short_ack", ack, 0);
    check_value("short_senack", senack, 0);
    check_value("short_no_dv", n_dv, dv0);
    dt = 1'b0;
    repeat (2) @(negedge clk);
    check_value("err_sticky", frame_err, 1);
    clear_err();

    // Illegal symbol in IDLE.
    bit0 = 1'b1; bit1 = 1'b1;
    wait_for(2, 1'b1, n);
    check_value("illegal_idle_lat", n, LAT);
    check_value("illegal_idle_ack", ack, 0);
    bit0 = 1'b0; bit1 = 1'b0;
    clear_err();

    // Illegal symbol while waiting in ACK.
    bit1 = 1'b1;
    wait_for(0, 1'b1, n);
    check_value("mid_ack_hi", ack, 1);
    bit0 = 1'b1;
    wait_for(2, 1'b1, n);
    check_value("illegal_ack_lat", n, LAT);
    check_value("illegal_ack_ack", ack, 0);
    bit0 = 1'b0; bit1 = 1'b0;
    clear_err();

    // Overrun: one symbol past a full word.
    send_word(8'h5A, WORD_W, 1'b0);
    bit1 = 1'b1;
    wait_for(2, 1'b1, n);
    check_value("overrun_ferr", frame_err, 1);
    check_value("overrun_lat", n, LAT);
    check_value("overrun_ack", ack, 0);
    check_value("overrun_count", bit_count, NB);
    bit1 = 1'b0;
    clear_err();

`ifdef X0RX_PARITY_EN
    send_word(8'h0F, WORD_W, 1'b0);
    send_dt(8'h0F);
    dv0 = n_dv;
    send_word(8'h0F, WORD_W, 1'b1);
    dt = 1'b1;
    wait_for(2, 1'b1, n);
    repeat (2) @(negedge clk);
    check_value("par_ferr", frame_err, 1);
    check_value("par_senack", senack, 0);
    check_value("par_dout", data_out, 8'h0F);
    check_value("par_no_dv", n_dv, dv0);
    dt = 1'b0;
    clear_err();
`endif

    // Reset in the middle of a word.
    send_word(8'h07, 3, 1'b0);
    bit1 = 1'b1;
    wait_for(0, 1'b1, n);
    reset = 1'b1; bit1 = 1'b0;
    @(negedge clk);
    check_value("midrst_ack", ack, 0);
    check_value("midrst_count", bit_count, 0);
    check_value("midrst_dout", data_out, 0);
    reset = 1'b0;
    exp_last = '0;
    repeat (3) @(negedge clk);
    send_word(8'h3C, WORD_W, 1'b0);
    send_dt(8'h3C);

    for (int k = 0; k < 3; k++) begin
      w = WORD_W'($urandom);
      send_word(w, WORD_W, 1'b0);
      send_dt(w);
    end

    repeat (4) @(negedge clk);
    check_value("sb_drained", sb_q.size(), 0);
    check_value("dv_total", n_dv, n_push);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
